// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, lane count and alignment helpers for the load/store unit
// Ports: none (package)
package lsu_pkg;

    localparam int LANES = 8;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    typedef enum logic [2:0] {IDLE, CREQ, CWAIT, DREQ, DWAIT, RESP} state_e;

    function automatic logic misaligned(input size_e sz, input logic [2:0] off);
        return (sz == SZ_H && off[0]) || (sz == SZ_W && |off[1:0]) || (sz == SZ_D && |off);
    endfunction

    function automatic logic [LANES-1:0] strobe(input size_e sz, input logic [2:0] off);
        logic [LANES-1:0] m;
        m = (sz == SZ_B) ? 8'h01 : (sz == SZ_H) ? 8'h03 : (sz == SZ_W) ? 8'h0f : 8'hff;
        return m << off;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane store shift/strobe and load shift/extend, shared by both ports
// Ports:
//   i_size, i_off, i_unsigned : access size, byte offset within the 8-byte word, zero-extend flag
//   i_wdata -> o_wdata, o_wstrb : right-aligned store data to lane-shifted data plus strobes
//   i_rdata -> o_rdata          : aligned 64-bit word to extended load result
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  size_e                 i_size,
    input  logic [2:0]            i_off,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [LANES-1:0]      o_wstrb,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] w_sh;
    logic                  w_neg;

    assign o_wdata = i_wdata << {i_off, 3'b000};
    assign o_wstrb = strobe(i_size, i_off);
    assign w_sh    = i_rdata >> {i_off, 3'b000};
    // Doubles have no extension, so req_unsigned is irrelevant for them.
    assign w_neg   = !i_unsigned && ((i_size == SZ_B) ? w_sh[7] : (i_size == SZ_H) ? w_sh[15] : w_sh[31]);
    assign o_rdata = (i_size == SZ_B) ? {{(DATA_WIDTH-8){w_neg}}, w_sh[7:0]} :
                     (i_size == SZ_H) ? {{(DATA_WIDTH-16){w_neg}}, w_sh[15:0]} :
                     (i_size == SZ_W) ? {{(DATA_WIDTH-32){w_neg}}, w_sh[31:0]} : w_sh;

endmodule

// File: rtl/lsu_crossbar.sv
// lsu_crossbar: single-outstanding load/store unit routing to a dcache port or an uncached device port
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   i_req_* / o_req_ready             : request handshake (store flag, address, data, size, unsigned)
//   o_resp_valid/o_resp_rdata/o_resp_err : one-cycle completion pulse with registered data/error
//   o_c_* / i_c_*                     : dcache request (8-byte aligned address) and response
//   o_d_* / i_d_*                     : device request (unaligned address), response and error
module lsu_crossbar
    import lsu_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 64,
    parameter int          DATA_WIDTH  = 64,
    parameter logic [31:0] CACHE_BASE  = 32'h8000_0000,
    parameter logic [31:0] CACHE_LIMIT = 32'h87ff_ffff,
    parameter int          DEV_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wen,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic                  o_c_req_valid,
    input  logic                  i_c_req_ready,
    output logic                  o_c_wen,
    output logic [31:0]           o_c_addr,
    output logic [DATA_WIDTH-1:0] o_c_wdata,
    output logic [LANES-1:0]      o_c_wstrb,
    input  logic                  i_c_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_c_rdata,
    output logic                  o_d_req_valid,
    input  logic                  i_d_req_ready,
    output logic                  o_d_wen,
    output logic [31:0]           o_d_addr,
    output logic [DATA_WIDTH-1:0] o_d_wdata,
    output logic [LANES-1:0]      o_d_wstrb,
    input  logic                  i_d_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_d_rdata,
    input  logic                  i_d_resp_err
);

    localparam int CNT_W = (DEV_TIMEOUT > 1) ? $clog2(DEV_TIMEOUT + 1) : 1;

    state_e                r_state, w_next;
    logic [31:0]           r_addr;
    size_e                 r_size;
    logic                  r_wen, r_uns, r_err;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_cach, w_mis, w_dev, w_to, w_c_done, w_d_done, w_done;
    logic [DATA_WIDTH-1:0] w_ld, w_wdata;
    logic [LANES-1:0]      w_wstrb;
    logic                  w_unused;

    assign w_unused = ^i_req_addr[ADDR_WIDTH-1:32];
    assign w_cach   = (i_req_addr[31:0] >= CACHE_BASE) && (i_req_addr[31:0] <= CACHE_LIMIT);
    assign w_mis    = misaligned(size_e'(i_req_size), i_req_addr[2:0]);
    assign w_dev    = (r_state == DREQ) || (r_state == DWAIT);
    // r_cnt counts device cycles already spent, so the DEV_TIMEOUT-th cycle is the last one.
    assign w_to     = (DEV_TIMEOUT != 0) && (r_cnt == CNT_W'(DEV_TIMEOUT - 1));
    assign w_c_done = i_c_resp_valid && ((r_state == CWAIT) || (r_state == CREQ && i_c_req_ready));
    assign w_d_done = i_d_resp_valid && ((r_state == DWAIT) || (r_state == DREQ && i_d_req_ready));
    assign w_done   = w_c_done || w_d_done;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .i_size     (r_size),
        .i_off      (r_addr[2:0]),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .i_rdata    (w_dev ? i_d_rdata : i_c_rdata),
        .o_wdata    (w_wdata),
        .o_wstrb    (w_wstrb),
        .o_rdata    (w_ld)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // A real device completion beats the timeout; the timeout beats a bare handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_req_valid) w_next = w_mis ? RESP : (w_cach ? CREQ : DREQ);
            CREQ:    if (i_c_req_ready) w_next = i_c_resp_valid ? RESP : CWAIT;
            CWAIT:   if (i_c_resp_valid) w_next = RESP;
            DREQ:    w_next = (w_d_done || w_to) ? RESP : (i_d_req_ready ? DWAIT : DREQ);
            DWAIT:   if (w_d_done || w_to) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready   = r_state == IDLE;
        o_resp_valid  = r_state == RESP;
        o_resp_rdata  = r_rdata;
        o_resp_err    = r_err;
        o_c_req_valid = r_state == CREQ;
        o_c_wen       = r_wen;
        o_c_addr      = {r_addr[31:3], 3'b000};
        o_c_wdata     = w_wdata;
        o_c_wstrb     = w_wstrb;
        o_d_req_valid = r_state == DREQ;
        o_d_wen       = r_wen;
        o_d_addr      = r_addr;
        o_d_wdata     = w_wdata;
        o_d_wstrb     = w_wstrb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_size  <= SZ_B;
            r_wen   <= 1'b0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cnt <= w_dev ? r_cnt + 1'b1 : '0;
            if (r_state == IDLE && i_req_valid) begin
                r_addr  <= i_req_addr[31:0];
                r_size  <= size_e'(i_req_size);
                r_wen   <= i_req_wen;
                r_uns   <= i_req_unsigned;
                r_wdata <= i_req_wdata;
            end
            // Entering RESP without a completion means misalignment or timeout: error, no data.
            if (r_state != RESP && w_next == RESP) begin
                r_rdata <= (w_done && !r_wen) ? w_ld : '0;
                r_err   <= !w_done || (w_d_done && i_d_resp_err);
            end
        end
    end

endmodule

// File: tb/tb_lsu_crossbar.sv
// tb_lsu_crossbar: randomized transaction bench with a timeline-based reference model
module tb_lsu_crossbar;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, o_req_ready, i_req_wen, i_req_unsigned;
    logic [63:0] i_req_addr, i_req_wdata;
    logic [1:0]  i_req_size;
    logic        o_resp_valid, o_resp_err;
    logic [63:0] o_resp_rdata;
    logic        o_c_req_valid, i_c_req_ready, o_c_wen, i_c_resp_valid;
    logic [31:0] o_c_addr;
    logic [63:0] o_c_wdata, i_c_rdata;
    logic [7:0]  o_c_wstrb;
    logic        o_d_req_valid, i_d_req_ready, o_d_wen, i_d_resp_valid, i_d_resp_err;
    logic [31:0] o_d_addr;
    logic [63:0] o_d_wdata, i_d_rdata;
    logic [7:0]  o_d_wstrb;

    always #5 clk = ~clk;

    lsu_crossbar #(.DEV_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
        .i_req_unsigned(i_req_unsigned),
        .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
        .o_c_req_valid(o_c_req_valid), .i_c_req_ready(i_c_req_ready), .o_c_wen(o_c_wen),
        .o_c_addr(o_c_addr), .o_c_wdata(o_c_wdata), .o_c_wstrb(o_c_wstrb),
        .i_c_resp_valid(i_c_resp_valid), .i_c_rdata(i_c_rdata),
        .o_d_req_valid(o_d_req_valid), .i_d_req_ready(i_d_req_ready), .o_d_wen(o_d_wen),
        .o_d_addr(o_d_addr), .o_d_wdata(o_d_wdata), .o_d_wstrb(o_d_wstrb),
        .i_d_resp_valid(i_d_resp_valid), .i_d_rdata(i_d_rdata), .i_d_resp_err(i_d_resp_err)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    logic        e_ready, e_cv, e_dv, e_rv, e_err, e_wen;
    logic [63:0] e_rdata, e_wdata;
    logic [31:0] e_caddr, e_daddr;
    logic [7:0]  e_strb;

    int          n_cv = 0, n_dv = 0, n_rv = 0;
    logic [7:0]  l_strb;
    logic [63:0] l_wdata;
    logic [31:0] l_addr;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [7:0] m_strb(input int sz, input int off);
        logic [7:0] s;
        s = '0;
        for (int b = 0; b < 8; b++) s[b] = (b >= off) && (b < off + (1 << sz));
        return s;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] d, input int sz, input int off, input bit uns);
        int          bits;
        logic [63:0] w, m;
        bits = 8 << sz;
        w = d >> (8 * off);
        if (bits == 64) return w;
        m = (64'd1 << bits) - 64'd1;
        w = w & m;
        if (!uns && w[bits-1]) w = w | ~m;
        return w;
    endfunction

    always @(negedge clk) begin
        if (o_c_req_valid) begin
            n_cv++;
            l_strb = o_c_wstrb;
            l_wdata = o_c_wdata;
            l_addr = o_c_addr;
        end
        if (o_d_req_valid) n_dv++;
        if (o_resp_valid) n_rv++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(o_req_ready), 64'(e_ready));
            chk("resp_valid", 64'(o_resp_valid), 64'(e_rv));
            chk("c_req_valid", 64'(o_c_req_valid), 64'(e_cv));
            chk("d_req_valid", 64'(o_d_req_valid), 64'(e_dv));
            chk("resp_rdata", o_resp_rdata, e_rdata);
            chk("resp_err", 64'(o_resp_err), 64'(e_err));
            if (e_cv) begin
                chk("c_addr", 64'(o_c_addr), 64'(e_caddr));
                chk("c_wdata", o_c_wdata, e_wdata);
                chk("c_wstrb", 64'(o_c_wstrb), 64'(e_strb));
                chk("c_wen", 64'(o_c_wen), 64'(e_wen));
            end
            if (e_dv) begin
                chk("d_addr", 64'(o_d_addr), 64'(e_daddr));
                chk("d_wdata", o_d_wdata, e_wdata);
                chk("d_wstrb", 64'(o_d_wstrb), 64'(e_strb));
                chk("d_wen", 64'(o_d_wen), 64'(e_wen));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        i_req_valid = 0;
        i_c_req_ready = 0;
        i_c_resp_valid = 0;
        i_d_req_ready = 0;
        i_d_resp_valid = 0;
        i_d_resp_err = 0;
        e_ready = 1;
        e_cv = 0;
        e_dv = 0;
        e_rv = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            set_idle();
        end
    endtask

    // Cycle 0 is the accept cycle. The responder raises ready in cycle 1+rd and the
    // response rv cycles later (same cycle when rv=0); the response pulse follows the
    // completion by one cycle. A device completion later than cycle TO becomes a timeout.
    task automatic run_txn(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                           input int sz, input bit uns, input int rd, input int rv,
                           input logic [63:0] rdata, input bit derr, input int abort_k);
        int off, c, e, vend;
        bit cach, mis, to, dn;
        off  = int'(addr[2:0]);
        cach = addr[31:0] >= 32'h8000_0000 && addr[31:0] <= 32'h87ff_ffff;
        mis  = (off % (1 << sz)) != 0;
        c    = 1 + rd + rv;
        to   = !mis && !cach && c > TO;
        e    = mis ? 1 : (to ? TO + 1 : c + 1);
        vend = mis ? 0 : (to ? ((1 + rd < TO) ? 1 + rd : TO) : 1 + rd);
        set_idle();
        i_req_valid = 1;
        i_req_wen = wen;
        i_req_addr = addr;
        i_req_wdata = wdata;
        i_req_size = 2'(sz);
        i_req_unsigned = uns;
        e_caddr = {addr[31:3], 3'b000};
        e_daddr = addr[31:0];
        e_wdata = wdata << (8 * off);
        e_strb = m_strb(sz, off);
        e_wen = wen;
        for (int k = 1; k <= e; k++) begin
            step();
            i_req_valid = 1'($urandom_range(0, 1));
            i_req_wen = 1'($urandom_range(0, 1));
            i_req_addr = {$urandom, $urandom};
            i_req_wdata = {$urandom, $urandom};
            i_req_size = 2'($urandom_range(0, 3));
            dn = !mis && k <= vend && k == 1 + rd;
            i_c_req_ready = cach && dn;
            i_c_resp_valid = cach && !mis && k == c;
            i_c_rdata = (k == c) ? rdata : {$urandom, $urandom};
            i_d_req_ready = !cach && dn;
            i_d_resp_valid = !cach && !mis && !to && k == c;
            i_d_resp_err = (k == c) ? derr : 1'($urandom_range(0, 1));
            i_d_rdata = (k == c) ? rdata : {$urandom, $urandom};
            e_ready = 0;
            e_cv = cach && !mis && k <= vend;
            e_dv = !cach && !mis && k <= vend;
            e_rv = k == e;
            if (k == e) begin
                e_rdata = (mis || to || wen) ? 64'd0 : m_load(rdata, sz, off, uns);
                e_err = mis || to || (!cach && derr);
            end
            if (k == abort_k) begin
                rst = 1;
                break;
            end
        end
        step();
        rst = 0;
        set_idle();
        if (abort_k != 0) begin
            e_rdata = 0;
            e_err = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          sz, rd, rv, b_cv, b_dv, b_rv;
        logic [63:0] a;
        rst = 1;
        i_req_wen = 0;
        i_req_addr = 0;
        i_req_wdata = 0;
        i_req_size = 0;
        i_req_unsigned = 0;
        i_c_rdata = 0;
        i_d_rdata = 0;
        set_idle();
        e_rdata = 0;
        e_err = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
        step();
        rst = 0;
        step();
        chk("reset_rdata", o_resp_rdata, 64'd0);
        chk("reset_ready", 64'(o_req_ready), 64'd1);

        run_txn(1, 64'h8000_0004, 64'hDEAD_BEEF, 2, 0, 0, 0, 64'd0, 0, 0);
        chk("st_strb", 64'(l_strb), 64'hF0);
        chk("st_wdata", l_wdata, 64'hDEAD_BEEF_0000_0000);
        chk("st_addr", 64'(l_addr), 64'h8000_0000);
        chk("st_err", 64'(o_resp_err), 64'd0);

        run_txn(0, 64'h8000_0003, 64'd0, 0, 0, 0, 0, 64'h0000_0000_8000_0000, 0, 0);
        chk("lb_signed", o_resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        run_txn(0, 64'h8000_0003, 64'd0, 0, 1, 0, 0, 64'h0000_0000_8000_0000, 0, 0);
        chk("lb_unsigned", o_resp_rdata, 64'h80);

        b_cv = n_cv; b_dv = n_dv;
        run_txn(0, 64'hA000_0001, 64'd0, 1, 0, 0, 0, 64'd0, 0, 0);
        chk("mis_err", 64'(o_resp_err), 64'd1);
        chk("mis_no_valid", 64'(n_cv - b_cv + n_dv - b_dv), 64'd0);

        b_dv = n_dv; b_rv = n_rv;
        run_txn(0, 64'hA000_0048, 64'd0, 3, 0, 3, 1, 64'h1234, 0, 0);
        chk("dev_valid_cycles", 64'(n_dv - b_dv), 64'd4);
        chk("dev_rdata", o_resp_rdata, 64'h1234);
        chk("dev_pulses", 64'(n_rv - b_rv), 64'd1);

        b_cv = n_cv; b_dv = n_dv;
        run_txn(0, 64'h8800_0000, 64'd0, 0, 0, 0, 0, 64'h7F, 0, 0);
        chk("limit_dev_d", 64'(n_dv - b_dv), 64'd1);
        chk("limit_dev_c", 64'(n_cv - b_cv), 64'd0);

        b_dv = n_dv;
        run_txn(0, 64'hA000_0000, 64'd0, 3, 0, 30, 0, 64'd0, 0, 0);
        chk("to_valid_cycles", 64'(n_dv - b_dv), 64'd8);
        chk("to_err", 64'(o_resp_err), 64'd1);
        chk("to_ready_after", 64'(o_req_ready), 64'd1);

        b_cv = n_cv; b_rv = n_rv;
        run_txn(0, 64'h8000_0010, 64'd0, 3, 0, 0, 5, 64'h55, 0, 2);
        chk("abort_no_resp", 64'(n_rv - b_rv), 64'd0);
        chk("abort_c_cycles", 64'(n_cv - b_cv), 64'd1);
        run_txn(0, 64'h8000_0010, 64'd0, 3, 0, 1, 1, 64'h0123_4567_89AB_CDEF, 0, 0);
        chk("post_abort_rdata", o_resp_rdata, 64'h0123_4567_89AB_CDEF);

        for (int i = 0; i < 400; i++) begin
            sz = $urandom_range(0, 3);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: a[31:0] = 32'h8000_0000 + ($urandom & 32'h07ff_ffff);
                1: a[31:0] = (($urandom_range(0, 3) == 0) ? 32'h7fff_fff8 :
                              ($urandom_range(0, 2) == 0) ? 32'h8000_0000 :
                              ($urandom_range(0, 1) == 0) ? 32'h87ff_fff8 : 32'h8800_0000) | ($urandom & 32'h7);
                default: ;
            endcase
            if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
            rd = $urandom_range(0, 10);
            rv = $urandom_range(0, 3);
            run_txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, sz, 1'($urandom_range(0, 1)),
                    rd, rv, {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0), 0);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_crossbar.md
Name: lsu_crossbar

Overview:
Parametrised load/store unit for the memory stage, replacing the combinational load-extend and finish path. It accepts one request per handshake, decodes cacheable against device address space, and routes the access to the dcache port or an uncached device port with valid/ready handshakes. It performs byte-lane alignment, store strobe generation, load sign/zero extension, misalignment detection and device timeout. Exactly one transaction is outstanding at a time.

Parameters:
ADDR_WIDTH, 64, request address width; only [31:0] is decoded and forwarded.
DATA_WIDTH, 64, data width; fixed lane count DATA_WIDTH/8 = 8.
CACHE_BASE, 32'h8000_0000, first cacheable address (inclusive).
CACHE_LIMIT, 32'h87ff_ffff, last cacheable address (inclusive).
DEV_TIMEOUT, 255, cycles to wait for a device handshake before an error response; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_wen  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned (lane 0)
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
req_unsigned  in  1  zero-extend the load when set
resp_valid  out  1  one-cycle pulse at completion
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores
resp_err  out  1  valid with resp_valid: misaligned access or timeout
c_req_valid / c_req_ready  out / in  1 / 1  dcache request handshake
c_wen  out  1  store to dcache
c_addr  out  32  dcache address, aligned to 8 bytes
c_wdata  out  DATA_WIDTH  lane-shifted store data
c_wstrb  out  8  byte strobes
c_resp_valid  in  1  dcache done; c_rdata is valid in this cycle
c_rdata  in  DATA_WIDTH  aligned 64-bit dcache line word
d_req_valid / d_req_ready  out / in  1 / 1  device request handshake
d_wen, d_addr (32), d_wdata, d_wstrb  out  -  same encoding as the c_* signals, but d_addr is unaligned
d_resp_valid  in  1  device done
d_rdata  in  DATA_WIDTH  device data, 64-bit word with lane order identical to the cache
d_resp_err  in  1  device error, ORed into resp_err

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; c_req_valid=0; d_req_valid=0; timeout counter=0.
- Reset mid-transaction aborts to IDLE on the next edge with no response. Downstream blocks share rst.
- Request accept: req_valid & req_ready. The unit latches addr, size, wen, unsigned, wdata and the decode result.
- Address decode: cacheable = CACHE_BASE <= addr[31:0] <= CACHE_LIMIT, compared unsigned.
- Misaligned: addr[size-1:0] != 0; a byte access is never misaligned.
  - State goes ACCEPT -> RESP. resp_valid with resp_err=1 one cycle after accept.
  - No downstream valid is ever raised for a misaligned request.
- Store strobes: wstrb = ((1<<(1<<size))-1) << addr[2:0]. wdata = req_wdata << (8*addr[2:0]).
- Load path:
  - word = rdata >> (8*addr[2:0]), then truncated to 8<<size bits.
  - The truncated value is sign-extended unless req_unsigned is set. Size 3 ignores req_unsigned.
- States:
  - IDLE: on accept, go to RESP if misaligned, else to CREQ (cacheable) or DREQ (device).
  - CREQ: c_req_valid=1, and all c_* outputs are held stable until c_req_ready. On c_req_ready: go to CWAIT, or go straight to RESP capturing c_rdata if c_resp_valid is high in the same cycle.
  - CWAIT: wait for c_resp_valid, capture data, then go to RESP.
  - DREQ / DWAIT: same as CREQ / CWAIT on the d_* ports. The timeout counter increments every cycle spent in DREQ or DWAIT. When it reaches DEV_TIMEOUT (and DEV_TIMEOUT != 0), go to RESP with err=1 and deassert d_req_valid.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. The counter is cleared.
- Latency: a cacheable load whose c_req_ready and c_resp_valid arrive on the first CREQ cycle gets resp_valid 2 cycles after accept. The minimum back-to-back issue rate is one request per 3 cycles.
- resp_rdata and resp_err are registered and hold their last value until the next RESP.

Decomposition:
- Package lsu_pkg holds:
  - the size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the state enum (IDLE, CREQ, CWAIT, DREQ, DWAIT, RESP);
  - the lane-count constant;
  - the misalignment and strobe functions.
- One sub-module, lsu_align: purely combinational. It performs the store shift/strobe and the load shift/extend, and is shared by both paths.

Test Plan:
- Store word to 0x8000_0004 with wdata 0xDEADBEEF -> c_wstrb=0xF0, c_wdata=0xDEADBEEF_00000000, c_addr=0x8000_0000, resp_err=0.
- Signed byte load from 0x8000_0003 with c_rdata=0x00000000_80000000 -> resp_rdata=0xFFFF_FFFF_FFFF_FF80. The same load with req_unsigned=1 -> 0x80.
- Half load from 0xA000_0001 -> resp_err=1 one cycle after accept; c_req_valid and d_req_valid stay 0 throughout.
- Device load from 0xA000_0048 with d_req_ready delayed 3 cycles and d_rdata=0x1234 -> d_req_valid held for 4 cycles, then resp_rdata=0x1234 as a one-cycle pulse. Address 0x8800_0000 must also route to the device port.
- DEV_TIMEOUT=8 and d_req_ready stuck at 0 -> resp_valid with resp_err=1 exactly 8 cycles after entering DREQ; req_ready=1 in the following cycle.
- rst asserted during CWAIT -> next cycle state is IDLE, c_req_valid=0, resp_valid never pulses; a fresh request is then accepted normally.
